// File: rtl/rr_arb_ctrl.sv
// ---------------------------------------------------------------------------
// rr_arb_ctrl
// Sequential control stage wrapped around an external combinational priority
// coder. The stage presents the request vector and round-robin pointer to the
// coder and takes back the selected index. It registers the grant, holds it
// while the winner keeps requesting and advances the pointer past each
// released winner. An optional hold limit revokes long grants.
//
// Parameters
//   REQWIDTH  log2 of requester count (N = 2**REQWIDTH)
//   MAX_HOLD  longest grant in cycles, 0 = unlimited (must be < 2**HOLDW)
//   HOLDW     width of the hold counter
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   req_i          level-held request vector, one bit per requester
//   coder_data_o   request vector to the priority coder
//   coder_prior_o  round-robin pointer to the priority coder
//   coder_num_i    index chosen by the priority coder (combinational)
//   gnt_o          registered one-hot grant
//   gnt_num_o      registered index of the granted requester
//   gnt_valid_o    high while a grant is active
//   timeout_o      one-cycle pulse when the hold limit revokes a grant
// ---------------------------------------------------------------------------
module rr_arb_ctrl #(
    parameter int REQWIDTH = 3,
    parameter int MAX_HOLD = 16,
    parameter int HOLDW    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [2**REQWIDTH-1:0]   req_i,
    output logic [2**REQWIDTH-1:0]   coder_data_o,
    output logic [REQWIDTH-1:0]      coder_prior_o,
    input  logic [REQWIDTH-1:0]      coder_num_i,
    output logic [2**REQWIDTH-1:0]   gnt_o,
    output logic [REQWIDTH-1:0]      gnt_num_o,
    output logic                     gnt_valid_o,
    output logic                     timeout_o
);

    localparam int N = 2**REQWIDTH;

    localparam logic [HOLDW-1:0]    CNT_ZERO   = {HOLDW{1'b0}};
    localparam logic [HOLDW-1:0]    CNT_ONE    = {{(HOLDW-1){1'b0}}, 1'b1};
    localparam logic [HOLDW-1:0]    CNT_SAT    = {HOLDW{1'b1}};
    localparam logic [HOLDW-1:0]    HOLD_LIMIT = HOLDW'(MAX_HOLD);
    localparam logic                LIMIT_EN   = (MAX_HOLD != 0);
    localparam logic [N-1:0]        GNT_ZERO   = {N{1'b0}};
    localparam logic [N-1:0]        GNT_ONE    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [REQWIDTH-1:0] PTR_ZERO   = {REQWIDTH{1'b0}};
    localparam logic [REQWIDTH-1:0] PTR_ONE    = {{(REQWIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        gnt_q, gnt_d;
    logic [REQWIDTH-1:0] gnt_num_q, gnt_num_d;
    logic                gnt_valid_q, gnt_valid_d;
    logic                timeout_q, timeout_d;
    logic [REQWIDTH-1:0] ptr_q, ptr_d;
    logic [HOLDW-1:0]    cnt_q, cnt_d;

    logic                sel_ok_s;
    logic                held_req_s;
    logic                limit_hit_s;

    // The coder sees the raw requests and the current pointer.
    assign coder_data_o  = req_i;
    assign coder_prior_o = ptr_q;

    // The coder's answer is only believed if it points at a live request;
    // this also covers the all-zero request vector.
    assign sel_ok_s    = (|req_i) && req_i[coder_num_i];
    assign held_req_s  = req_i[gnt_num_q];
    assign limit_hit_s = LIMIT_EN && (cnt_q == HOLD_LIMIT);

    assign gnt_o       = gnt_q;
    assign gnt_num_o   = gnt_num_q;
    assign gnt_valid_o = gnt_valid_q;
    assign timeout_o   = timeout_q;

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_num_d   = gnt_num_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (sel_ok_s) begin
                    state_d     = GRANT;
                    gnt_d       = GNT_ONE << coder_num_i;
                    gnt_num_d   = coder_num_i;
                    gnt_valid_d = 1'b1;
                    cnt_d       = CNT_ONE;
                end else begin
                    gnt_d       = GNT_ZERO;
                    gnt_valid_d = 1'b0;
                    cnt_d       = CNT_ZERO;
                end
            end
            GRANT: begin
                if (!held_req_s || limit_hit_s) begin
                    // Release: always pass through IDLE so a re-grant of the
                    // same requester still sees one dead cycle. gnt_num keeps
                    // the last winner for observability.
                    state_d     = IDLE;
                    gnt_d       = GNT_ZERO;
                    gnt_valid_d = 1'b0;
                    cnt_d       = CNT_ZERO;
                    ptr_d       = gnt_num_q + PTR_ONE;
                    // A limit hit coinciding with the request dropping is an
                    // ordinary release, not a revocation.
                    timeout_d   = held_req_s && limit_hit_s;
                end else begin
                    if (cnt_q == CNT_SAT) begin
                        cnt_d = cnt_q;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = GNT_ZERO;
                gnt_valid_d = 1'b0;
                cnt_d       = CNT_ZERO;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_ZERO;
            gnt_num_q   <= PTR_ZERO;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= PTR_ZERO;
            cnt_q       <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_num_q   <= gnt_num_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_ctrl
// Self-checking bench for rr_arb_ctrl. Two instances share clock, reset and
// requests: u_dut uses the default hold limit (16), u_dut_t uses a limit of 4
// for the revocation scenarios. Each instance has its own behavioural coder.
// Every scenario is a table of per-cycle rows (reset, request, expected
// grant state after the edge); expected values go into a queue when the row
// is driven and are popped and compared once the edge has happened.
// ---------------------------------------------------------------------------
module tb_rr_arb_ctrl;

    typedef struct packed {
        logic       rst;
        logic [7:0] req;
        logic       v;
        logic [2:0] n;
        logic [2:0] p;
        logic       t;
    } row_t;

    logic       clk;
    logic       rst;
    logic [7:0] req;

    logic [7:0] cdata_s,  cdata_t_s;
    logic [2:0] cprior_s, cprior_t_s;
    logic [2:0] cnum_s,   cnum_t_s;
    logic [7:0] gnt_s,    gnt_t_s;
    logic [2:0] gnum_s,   gnum_t_s;
    logic       gvld_s,   gvld_t_s;
    logic       tout_s,   tout_t_s;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] exp_q[$];

    // Coder model: the pointer wins if it requests, else the highest set bit.
    function automatic logic [2:0] coder(input logic [7:0] d, input logic [2:0] p);
        if (d[p]) return p;
        for (int i = 7; i >= 0; i--) begin
            if (d[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    function automatic row_t mk(input logic r, input logic [7:0] q, input logic v,
                                input logic [2:0] n, input logic [2:0] p, input logic t);
        row_t x;
        x.rst = r; x.req = q; x.v = v; x.n = n; x.p = p; x.t = t;
        return x;
    endfunction

    // Packed expectation: {gnt, gnt_num, valid, timeout, prior, coder_data}.
    function automatic logic [23:0] expv(input row_t x);
        logic [7:0] g;
        g = x.v ? (8'h01 << x.n) : 8'h00;
        return {g, x.n, x.v, x.t, x.p, x.req};
    endfunction

    assign cnum_s   = coder(cdata_s, cprior_s);
    assign cnum_t_s = coder(cdata_t_s, cprior_t_s);

    wire [23:0] obs_s   = {gnt_s, gnum_s, gvld_s, tout_s, cprior_s, cdata_s};
    wire [23:0] obs_t_s = {gnt_t_s, gnum_t_s, gvld_t_s, tout_t_s, cprior_t_s, cdata_t_s};

    rr_arb_ctrl #(.REQWIDTH(3), .MAX_HOLD(16), .HOLDW(8)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .coder_data_o(cdata_s), .coder_prior_o(cprior_s), .coder_num_i(cnum_s),
        .gnt_o(gnt_s), .gnt_num_o(gnum_s), .gnt_valid_o(gvld_s), .timeout_o(tout_s)
    );

    rr_arb_ctrl #(.REQWIDTH(3), .MAX_HOLD(4), .HOLDW(8)) u_dut_t (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .coder_data_o(cdata_t_s), .coder_prior_o(cprior_t_s), .coder_num_i(cnum_t_s),
        .gnt_o(gnt_t_s), .gnt_num_o(gnum_t_s), .gnt_valid_o(gvld_t_s), .timeout_o(tout_t_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        row_t rows[$];
        logic [23:0] e;
        rows.push_back(mk(1'b1, 8'hFF, 1'b0, 3'd0, 3'd0, 1'b0));
        rows.push_back(mk(1'b1, 8'hFF, 1'b0, 3'd0, 3'd0, 1'b0));
        rows.push_back(mk(1'b0, 8'hFF, 1'b1, 3'd0, 3'd0, 1'b0));
        rows.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 3'd1, 1'b0));
        rows.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 3'd1, 1'b0));
        foreach (rows[i]) begin
            rst = rows[i].rst; req = rows[i].req;
            exp_q.push_back(expv(rows[i]));
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL reset row %0d: got {gnt,num,vld,to,prior,data}=%h expected %h", i, obs_s, e);
            end
        end
    endtask

    task automatic test_single();
        row_t rows[$];
        logic [23:0] e;
        rows.push_back(mk(1'b1, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0));
        for (int k = 0; k < 5; k++) rows.push_back(mk(1'b0, 8'h01, 1'b1, 3'd0, 3'd0, 1'b0));
        rows.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 3'd1, 1'b0));
        rows.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 3'd1, 1'b0));
        foreach (rows[i]) begin
            rst = rows[i].rst; req = rows[i].req;
            exp_q.push_back(expv(rows[i]));
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL single row %0d: got {gnt,num,vld,to,prior,data}=%h expected %h", i, obs_s, e);
            end
        end
    endtask

    task automatic test_rotation();
        row_t rows[$];
        logic [23:0] e;
        logic [2:0] g;
        logic [7:0] m;
        rows.push_back(mk(1'b1, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0));
        for (int k = 0; k < 9; k++) begin
            g = 3'(k % 8);
            m = 8'h01 << g;
            rows.push_back(mk(1'b0, 8'hFF, 1'b1, g, g, 1'b0));
            rows.push_back(mk(1'b0, 8'hFF, 1'b1, g, g, 1'b0));
            rows.push_back(mk(1'b0, 8'hFF & ~m, 1'b0, g, g + 3'd1, 1'b0));
        end
        foreach (rows[i]) begin
            rst = rows[i].rst; req = rows[i].req;
            exp_q.push_back(expv(rows[i]));
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL rotation row %0d: got {gnt,num,vld,to,prior,data}=%h expected %h", i, obs_s, e);
            end
        end
    endtask

    task automatic test_wrap_exclusion();
        row_t rows[$];
        logic [23:0] e;
        rows.push_back(mk(1'b1, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0));
        rows.push_back(mk(1'b0, 8'h40, 1'b1, 3'd6, 3'd0, 1'b0));
        rows.push_back(mk(1'b0, 8'h00, 1'b0, 3'd6, 3'd7, 1'b0));
        rows.push_back(mk(1'b0, 8'h81, 1'b1, 3'd7, 3'd7, 1'b0));
        rows.push_back(mk(1'b0, 8'h81, 1'b1, 3'd7, 3'd7, 1'b0));
        rows.push_back(mk(1'b0, 8'h01, 1'b0, 3'd7, 3'd0, 1'b0));
        rows.push_back(mk(1'b0, 8'h00, 1'b0, 3'd7, 3'd0, 1'b0));
        rows.push_back(mk(1'b0, 8'h03, 1'b1, 3'd0, 3'd0, 1'b0));
        rows.push_back(mk(1'b0, 8'h01, 1'b1, 3'd0, 3'd0, 1'b0));
        rows.push_back(mk(1'b0, 8'h03, 1'b1, 3'd0, 3'd0, 1'b0));
        rows.push_back(mk(1'b0, 8'h01, 1'b1, 3'd0, 3'd0, 1'b0));
        rows.push_back(mk(1'b0, 8'h02, 1'b0, 3'd0, 3'd1, 1'b0));
        rows.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 3'd1, 1'b0));
        foreach (rows[i]) begin
            rst = rows[i].rst; req = rows[i].req;
            exp_q.push_back(expv(rows[i]));
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL wrap row %0d: got {gnt,num,vld,to,prior,data}=%h expected %h", i, obs_s, e);
            end
        end
    endtask

    task automatic test_midreset_idle();
        row_t rows[$];
        logic [23:0] e;
        rows.push_back(mk(1'b1, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0));
        rows.push_back(mk(1'b0, 8'h02, 1'b1, 3'd1, 3'd0, 1'b0));
        rows.push_back(mk(1'b0, 8'h00, 1'b0, 3'd1, 3'd2, 1'b0));
        rows.push_back(mk(1'b0, 8'h20, 1'b1, 3'd5, 3'd2, 1'b0));
        rows.push_back(mk(1'b0, 8'h20, 1'b1, 3'd5, 3'd2, 1'b0));
        rows.push_back(mk(1'b1, 8'h20, 1'b0, 3'd0, 3'd0, 1'b0));
        for (int k = 0; k < 20; k++) rows.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0));
        foreach (rows[i]) begin
            rst = rows[i].rst; req = rows[i].req;
            exp_q.push_back(expv(rows[i]));
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL midreset row %0d: got {gnt,num,vld,to,prior,data}=%h expected %h", i, obs_s, e);
            end
        end
    endtask

    // Checks the MAX_HOLD=4 instance: revocation with the request still up,
    // immediate re-grant through the coder fallback, then a limit hit that
    // coincides with the request dropping (no pulse).
    task automatic test_timeout();
        row_t rows[$];
        logic [23:0] e;
        rows.push_back(mk(1'b1, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0));
        for (int k = 0; k < 4; k++) rows.push_back(mk(1'b0, 8'h08, 1'b1, 3'd3, 3'd0, 1'b0));
        rows.push_back(mk(1'b0, 8'h08, 1'b0, 3'd3, 3'd4, 1'b1));
        rows.push_back(mk(1'b0, 8'h08, 1'b1, 3'd3, 3'd4, 1'b0));
        rows.push_back(mk(1'b0, 8'h00, 1'b0, 3'd3, 3'd4, 1'b0));
        for (int k = 0; k < 4; k++) rows.push_back(mk(1'b0, 8'h08, 1'b1, 3'd3, 3'd4, 1'b0));
        rows.push_back(mk(1'b0, 8'h00, 1'b0, 3'd3, 3'd4, 1'b0));
        rows.push_back(mk(1'b0, 8'h00, 1'b0, 3'd3, 3'd4, 1'b0));
        foreach (rows[i]) begin
            rst = rows[i].rst; req = rows[i].req;
            exp_q.push_back(expv(rows[i]));
            @(posedge clk); @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_t_s !== e) begin
                n_fail++;
                $display("FAIL timeout row %0d: got {gnt,num,vld,to,prior,data}=%h expected %h", i, obs_t_s, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        test_reset();
        test_single();
        test_rotation();
        test_wrap_exclusion();
        test_midreset_idle();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
